// File: rtl/traffic_light_ctrl.sv
// N-direction traffic-light sequencer with tick prescaler and override.
// Optional TL_FLASH_EN: flashing yellow on all channels while En=0.
module traffic_light_ctrl #(
  parameter int N_DIR    = 2,
  parameter int TICK_DIV = 50000000,
  parameter int T_GREEN  = 5,
  parameter int T_YELLOW = 2,
  parameter int T_ALLRED = 1,
  parameter int CNT_W    = 8,
  localparam int DW      = $clog2(N_DIR),
  localparam int PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               En,
  input  logic               enSet,
  input  logic [2*N_DIR-1:0] inset,
  output logic [2*N_DIR-1:0] code,
  output logic [N_DIR-1:0]   LEDR_R,
  output logic [N_DIR-1:0]   LEDR_Y,
  output logic [N_DIR-1:0]   LEDR_G,
  output logic [1:0]         phase,
  output logic [DW-1:0]      dir,
  output logic               cycle_done
);

  typedef enum logic [1:0] {
    ALLRED = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } phase_e;

  localparam logic [PW-1:0]    P_MAX  = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] LD_AR  = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] LD_GR  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_YE  = CNT_W'(T_YELLOW - 1);
  localparam logic [DW-1:0]    D_LAST = DW'(N_DIR - 1);

  phase_e             phase_q, phase_d;
  logic [DW-1:0]      dir_q, dir_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic               enset_q;
  logic               cd_q, cd_d;
  logic [2*N_DIR-1:0] code_q, code_d;
  logic [N_DIR-1:0]   r_q, r_d, y_q, y_d, g_q, g_d;
  logic               run, tick, rel;
`ifdef TL_FLASH_EN
  logic               flash_q, flash_d;
`endif

  // Prescaler, phase timer and sequencer next state.
  always_comb begin
    phase_d = phase_q;
    dir_d   = dir_q;
    timer_d = timer_q;
    presc_d = presc_q;
    cd_d    = 1'b0;
    run     = En && !enSet;
    tick    = run && (presc_q == P_MAX);
    rel     = enset_q && !enSet;
`ifdef TL_FLASH_EN
    flash_d = 1'b0;
`endif
    if (rel) begin
      phase_d = ALLRED;
      timer_d = LD_AR;
      presc_d = '0;
    end else if (run) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else begin
          unique case (phase_q)
            ALLRED: begin
              phase_d = GREEN;
              timer_d = LD_GR;
            end
            GREEN: begin
              phase_d = YELLOW;
              timer_d = LD_YE;
            end
            YELLOW: begin
              phase_d = ALLRED;
              timer_d = LD_AR;
              if (dir_q == D_LAST) begin
                dir_d = '0;
                cd_d  = 1'b1;
              end else begin
                dir_d = dir_q + 1'b1;
              end
            end
            default: begin
              phase_d = ALLRED;
              timer_d = LD_AR;
            end
          endcase
        end
      end
    end
`ifdef TL_FLASH_EN
    else if (!En) begin
      presc_d = (presc_q == P_MAX) ? '0 : presc_q + 1'b1;
      flash_d = (presc_q == P_MAX) ? !flash_q : flash_q;
    end
`endif
  end

  // Light code and LED decode from the next-state value.
  always_comb begin
    code_d = '0;
    r_d    = '0;
    y_d    = '0;
    g_d    = '0;
    if (!En) begin
`ifdef TL_FLASH_EN
      if (flash_d) code_d = {N_DIR{2'b01}};
`endif
    end else if (enSet) begin
      code_d = inset;
    end else begin
      for (int i = 0; i < N_DIR; i++) begin
        if (DW'(i) == dir_d) begin
          unique case (1'b1)
            phase_d == GREEN:  code_d[2*i +: 2] = 2'b11;
            phase_d == YELLOW: code_d[2*i +: 2] = 2'b01;
            default:           code_d[2*i +: 2] = 2'b00;
          endcase
        end
      end
    end
    for (int i = 0; i < N_DIR; i++) begin
      r_d[i] = code_d[2*i +: 2] == 2'b00;
      y_d[i] = code_d[2*i +: 2] == 2'b01;
      g_d[i] = code_d[2*i +: 2] == 2'b11;
    end
    if (!En) r_d = '0;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= ALLRED;
      dir_q   <= '0;
      timer_q <= LD_AR;
      presc_q <= '0;
      enset_q <= 1'b0;
      cd_q    <= 1'b0;
      code_q  <= '0;
      r_q     <= '0;
      y_q     <= '0;
      g_q     <= '0;
`ifdef TL_FLASH_EN
      flash_q <= 1'b0;
`endif
    end else begin
      phase_q <= phase_d;
      dir_q   <= dir_d;
      timer_q <= timer_d;
      presc_q <= presc_d;
      enset_q <= enSet;
      cd_q    <= cd_d;
      code_q  <= code_d;
      r_q     <= r_d;
      y_q     <= y_d;
      g_q     <= g_d;
`ifdef TL_FLASH_EN
      flash_q <= flash_d;
`endif
    end
  end

  assign code       = code_q;
  assign LEDR_R     = r_q;
  assign LEDR_Y     = y_q;
  assign LEDR_G     = g_q;
  assign phase      = phase_q;
  assign dir        = dir_q;
  assign cycle_done = cd_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl, N_DIR=2, TICK_DIV=4.
// Reference model works on elapsed running time, not on FSM state.
module tb_traffic_light_ctrl;

  localparam int N  = 2;
  localparam int TD = 4;
  localparam int TG = 3;
  localparam int TY = 2;
  localparam int TA = 1;
  localparam int L  = (TA + TG + TY) * TD;

  typedef struct {
    logic [3:0] code;
    logic [1:0] r;
    logic [1:0] y;
    logic [1:0] g;
    int         ph;
    int         dr;
    bit         cd;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       En = 1'b0;
  logic       enSet = 1'b0;
  logic [3:0] inset = '0;
  logic [3:0] code;
  logic [1:0] LEDR_R, LEDR_Y, LEDR_G;
  logic [1:0] phase;
  logic [0:0] dir;
  logic       cycle_done;

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];

  int   t_run;
  int   base;
  bit   prev_es;

  traffic_light_ctrl #(
    .N_DIR(N), .TICK_DIV(TD), .T_GREEN(TG),
    .T_YELLOW(TY), .T_ALLRED(TA), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .En(En), .enSet(enSet),
    .inset(inset), .code(code), .LEDR_R(LEDR_R),
    .LEDR_Y(LEDR_Y), .LEDR_G(LEDR_G), .phase(phase),
    .dir(dir), .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h expected %0h",
               nm, $time, act, exp);
    end
  endtask

  function automatic int dir_of(int t, int b);
    return (b + t / L) % N;
  endfunction

  function automatic int ph_of(int t);
    int r = t % L;
    if (r < TA * TD) return 0;
    if (r < (TA + TG) * TD) return 1;
    return 2;
  endfunction

  task automatic model_reset();
    t_run   = 0;
    base    = 0;
    prev_es = 0;
  endtask

  task automatic model_step(bit en, bit es, logic [3:0] ins);
    exp_t e;
    bit   rel = prev_es && !es;
    bit   adv = 0;
    if (rel) begin
      base  = dir_of(t_run, base);
      t_run = 0;
    end else if (en && !es) begin
      t_run++;
      adv = 1;
    end
    prev_es = es;
    e.ph = ph_of(t_run);
    e.dr = dir_of(t_run, base);
    e.cd = adv && (t_run % L == 0) && (e.dr == 0);
    e.code = '0;
    if (!en) e.code = '0;
    else if (es) e.code = ins;
    else if (e.ph == 1) e.code[2*e.dr +: 2] = 2'b11;
    else if (e.ph == 2) e.code[2*e.dr +: 2] = 2'b01;
    for (int i = 0; i < N; i++) begin
      e.r[i] = en && (e.code[2*i +: 2] == 2'b00);
      e.y[i] = e.code[2*i +: 2] == 2'b01;
      e.g[i] = e.code[2*i +: 2] == 2'b11;
    end
    q.push_back(e);
  endtask

  task automatic drive(bit en, bit es, logic [3:0] ins);
    @(negedge clk);
    En    = en;
    enSet = es;
    inset = ins;
    model_step(en, es, ins);
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_code"}, int'(code), 0);
    chk({nm, "_leds"}, int'({LEDR_R, LEDR_Y, LEDR_G}), 0);
    chk({nm, "_phase"}, int'(phase), 0);
    chk({nm, "_dir"}, int'(dir), 0);
    chk({nm, "_cd"}, int'(cycle_done), 0);
  endtask

  task automatic async_rst();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    rst_n = 1'b1;
    q.delete();
    model_reset();
  endtask

  // Monitor: compare each registered output set with the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && q.size() > 0) begin
        e = q.pop_front();
        chk("code", int'(code), int'(e.code));
        chk("ledr_r", int'(LEDR_R), int'(e.r));
        chk("ledr_y", int'(LEDR_Y), int'(e.y));
        chk("ledr_g", int'(LEDR_G), int'(e.g));
        chk("phase", int'(phase), e.ph);
        chk("dir", int'(dir), e.dr);
        chk("cycle_done", int'(cycle_done), int'(e.cd));
      end
    end
  end

  // Stimulus: directed opening, then random segments.
  initial begin
    int mode;
    int len;
    logic [3:0] ins;
    model_reset();
    #12;
    chk_zero("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) drive(1, 0, 4'h0);
    for (int i = 0; i < 6; i++) drive(1, 0, 4'h0);
    for (int i = 0; i < 20; i++) drive(1, 1, 4'b1101);
    for (int i = 0; i < 8; i++) drive(1, 1, 4'b1010);
    for (int i = 0; i < 30; i++) drive(1, 0, 4'h0);
    for (int i = 0; i < 4; i++) drive(0, 1, 4'b1111);
    for (int i = 0; i < 4; i++) drive(1, 0, 4'h0);
    for (int i = 0; i < 10; i++) drive(0, 0, 4'h0);
    for (int i = 0; i < 40; i++) drive(1, 0, 4'h0);
    async_rst();
    for (int i = 0; i < 30; i++) drive(1, 0, 4'h0);
    for (int s = 0; s < 60; s++) begin
      mode = $urandom_range(0, 9);
      if (mode <= 5) begin
        len = $urandom_range(5, 60);
        for (int i = 0; i < len; i++) drive(1, 0, 4'h0);
      end else if (mode <= 7) begin
        len = $urandom_range(1, 25);
        ins = 4'($urandom_range(0, 15));
        for (int i = 0; i < len; i++) begin
          if ($urandom_range(0, 1) == 1)
            ins = 4'($urandom_range(0, 15));
          drive(1, 1, ins);
        end
      end else if (mode == 8) begin
        len = $urandom_range(1, 15);
        for (int i = 0; i < len; i++)
          drive(0, 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)));
      end else begin
        async_rst();
      end
    end
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
